// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the MEM stage and a word-wide data memory.
// Handles byte/half/word sizing, alignment errors, sign extension and read-modify-write
// for sub-word stores.
module mem_access_unit #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StMerge,
      StWrite,
      StResp,
      StErr
   } state_e;

   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;
   localparam logic [1:0] SzBad  = 2'b11;

   state_e              state_q, state_d;
   logic [1:0]          offset_q;
   logic [1:0]          size_q;
   logic                signed_q;
   logic                write_q;
   logic [15:0]         wdata_q;
   logic [31:0]         word_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;

   logic                accept;
   logic                req_err;
   logic [31:0]         merged;
   logic [31:0]         load_data;

   // Address bits above the memory window wrap away by design.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   assign accept = req_valid && req_ready;

   // Decode illegal size and misalignment of the incoming request.
   always_comb begin
      req_err = 1'b0;
      unique case (req_size)
         SzHalf:  req_err = req_addr[0];
         SzWord:  req_err = (req_addr[1:0] != 2'b00);
         SzBad:   req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err) begin
                  state_d = StErr;
               end else if (req_write && (req_size == SzWord)) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = write_q ? StMerge : StResp;
         StMerge: state_d = StWrite;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Replace the target byte/half lanes of the captured word with the store data.
   always_comb begin
      merged = word_q;
      if (size_q == SzByte) begin
         merged[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{offset_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   // Select the loaded lane and extend it.
   always_comb begin
      logic [7:0]  lane8;
      logic [15:0] lane16;
      lane8     = word_q[{offset_q, 3'b000} +: 8];
      lane16    = word_q[{offset_q[1], 4'b0000} +: 16];
      load_data = word_q;
      if (size_q == SzByte) begin
         load_data = {{24{signed_q & lane8[7]}}, lane8};
      end else if (size_q == SzHalf) begin
         load_data = {{16{signed_q & lane16[15]}}, lane16};
      end
   end

   // State register, latched request fields and memory-port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         offset_q    <= 2'b00;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         word_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            offset_q <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            wdata_q  <= req_wdata[15:0];
            // Errored requests never touch the memory port, so its registers hold.
            if (!req_err) begin
               mem_addr_q <= req_addr[ADDR_W+1:2];
               if (req_write && (req_size == SzWord)) begin
                  mem_wdata_q <= req_wdata;
               end
            end
         end
         if (state_q == StRead) begin
            word_q <= mem_rdata;
         end
         if (state_q == StMerge) begin
            mem_wdata_q <= merged;
         end
      end
   end

   // Outputs decoded from state.
   always_comb begin
      req_ready  = (state_q == StIdle);
      mem_rd     = (state_q == StRead);
      mem_wr     = (state_q == StWrite);
      resp_valid = (state_q == StResp) || (state_q == StErr);
      resp_err   = (state_q == StErr);
      resp_rdata = ((state_q == StResp) && !write_q) ? load_data : 32'h0;
      mem_addr   = mem_addr_q;
      mem_wdata  = mem_wdata_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected responses and writes,
// monitors pop and compare whenever the DUT presents them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   resp_t exp_q[$];
   wr_t   wr_q[$];

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int rd_count  = 0;
   int exp_reads = 0;

   logic [31:0] mem [32];

   mem_access_unit #(.ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory model: combinational read, write on the falling edge.
   assign mem_rdata = mem[mem_addr];
   always @(negedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Response monitor.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'h1, 32'h0);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_cycle", cyc, e.cyc);
         end
      end
   end

   // Memory-port monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd) rd_count++;
         if (mem_wr) begin
            chk("rd_wr_overlap", {31'b0, mem_rd}, 32'h0);
            if (wr_q.size() == 0) begin
               chk("unexpected_write", 32'h1, 32'h0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("write_addr", {27'b0, mem_addr}, {27'b0, w.addr});
               chk("write_data", mem_wdata, w.data);
            end
         end
      end
   end

   // Issue one request; lat is the response cycle counted from the accept edge.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input int lat, input logic [31:0] exp_wd, input logic track);
      int n;
      @(negedge clk);
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'h1, 32'h0);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (track) begin
         exp_q.push_back('{err: exp_err, rdata: exp_rd, cyc: cyc + lat - 1});
         if (w && !exp_err) wr_q.push_back('{addr: a[6:2], data: exp_wd});
      end
      if (!exp_err && (!w || sz != 2'b10)) exp_reads++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state and idle quiet period.
      @(negedge clk);
      chk("rst_ctrl", {27'b0, req_ready, resp_valid, resp_err, mem_rd, mem_wr}, 32'h10);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_mem_addr", {27'b0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_quiet", {29'b0, mem_rd, mem_wr, resp_valid}, 32'h0);
      end

      // Word store / word load.
      do_req(1, 2'b10, 0, 32'h0C, 32'hDEADBEEF, 0, 32'h0, 2, 32'hDEADBEEF, 1);
      do_req(0, 2'b10, 1, 32'h0C, 32'h0, 0, 32'hDEADBEEF, 2, 32'h0, 1);

      // Byte store by read-modify-write, then byte loads.
      do_req(1, 2'b10, 0, 32'h0C, 32'h11223344, 0, 32'h0, 2, 32'h11223344, 1);
      do_req(1, 2'b00, 0, 32'h0D, 32'h000000AA, 0, 32'h0, 4, 32'h1122AA44, 1);
      do_req(0, 2'b00, 1, 32'h0D, 32'h0, 0, 32'hFFFFFFAA, 2, 32'h0, 1);
      do_req(0, 2'b00, 0, 32'h0D, 32'h0, 0, 32'h000000AA, 2, 32'h0, 1);
      do_req(0, 2'b00, 1, 32'h0F, 32'h0, 0, 32'h00000011, 2, 32'h0, 1);

      // Half loads.
      do_req(1, 2'b10, 0, 32'h0C, 32'h80001234, 0, 32'h0, 2, 32'h80001234, 1);
      do_req(0, 2'b01, 1, 32'h0E, 32'h0, 0, 32'hFFFF8000, 2, 32'h0, 1);
      do_req(0, 2'b01, 0, 32'h0E, 32'h0, 0, 32'h00008000, 2, 32'h0, 1);
      do_req(0, 2'b01, 1, 32'h0C, 32'h0, 0, 32'h00001234, 2, 32'h0, 1);

      // Half store into the upper lane.
      do_req(1, 2'b01, 0, 32'h0E, 32'h0000BEEF, 0, 32'h0, 4, 32'hBEEF1234, 1);
      do_req(0, 2'b10, 0, 32'h0C, 32'h0, 0, 32'hBEEF1234, 2, 32'h0, 1);

      // Errors: misaligned half, misaligned word, illegal size.
      do_req(0, 2'b01, 1, 32'h01, 32'h0, 1, 32'h0, 1, 32'h0, 1);
      do_req(1, 2'b10, 0, 32'h06, 32'h12345678, 1, 32'h0, 1, 32'h0, 1);
      do_req(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1, 32'h0, 1);

      // Address wrap.
      do_req(1, 2'b10, 0, 32'h80, 32'hCAFEF00D, 0, 32'h0, 2, 32'hCAFEF00D, 1);
      do_req(0, 2'b10, 0, 32'h00, 32'h0, 0, 32'hCAFEF00D, 2, 32'h0, 1);

      // Reset during a byte store's MERGE cycle.
      do_req(1, 2'b10, 0, 32'h14, 32'h55667788, 0, 32'h0, 2, 32'h55667788, 1);
      do_req(1, 2'b00, 0, 32'h15, 32'h00000099, 0, 32'h0, 4, 32'h0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_async_ctrl", {28'b0, req_ready, mem_rd, mem_wr, resp_valid}, 32'h8);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_mem_unchanged", mem[5], 32'h55667788);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("resp_queue_drained", exp_q.size(), 32'h0);
      chk("write_queue_drained", wr_q.size(), 32'h0);
      chk("read_strobe_count", rd_count, exp_reads);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the MEM pipeline stage and the word-wide data memory. Accepts one byte-addressed load or store per handshake and resolves byte/halfword/word size, alignment, sign extension and sub-word store merging. Sub-word stores use read-modify-write over the 32-bit word port. Drives the data memory's 5-bit word address, write data, read strobe and write strobe, and returns one response pulse per request.

## Interface
- ADDR_W, 5, word-address width; must match the data memory depth of 2^ADDR_W words.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address; bits above ADDR_W+1 ignored (wrap modulo 2^(ADDR_W+2)).
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_err  out  1  valid with resp_valid; misaligned or illegal size.
- resp_rdata  out  32  load result; 0 for stores and errors.
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2].
- mem_wdata  out  32  full word to write.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe; memory commits mid-cycle on the falling edge.
- mem_rdata  in  32  combinational memory read data.

## Operation
- Byte lanes are little-endian: byte at offset k occupies bits [8k+7:8k]; half at addr[1] occupies [16*addr[1]+15:16*addr[1]].
- Request is latched on a rising edge with req_valid && req_ready: addr, size, signed, write, wdata.
- Error check at accept:
  - size 11 is illegal.
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - On error, no memory strobe is issued.
- States:
  - IDLE: req_ready=1. Accept goes to ERR on error, WRITE for a word store, READ otherwise.
  - READ: mem_rd=1, mem_addr driven; mem_rdata captured at the end of the cycle. Next state is MERGE for a sub-word store, RESP for a load.
  - MERGE: captured word with the target byte/half lanes replaced by req_wdata[7:0]/[15:0] is loaded into the mem_wdata register. Next state is WRITE.
  - WRITE: mem_wr=1 for exactly one cycle with stable mem_addr/mem_wdata. Next state is RESP.
  - RESP: resp_valid=1, resp_err=0. Next state is IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. Next state is IDLE.
- Load result: selected lane, extended per req_signed; word loads ignore req_signed.
- Store response: resp_rdata=0.
- All mem_* and resp_* outputs are registered/decoded from state. mem_rd and mem_wr are never high simultaneously.
- mem_addr and mem_wdata hold their last values outside READ/WRITE; strobes are 0 there.

## Timing
- Cycle 0 = accept edge.
- Load: READ in cycle 1, resp_valid in cycle 2 (latency 2).
- Word store: WRITE in cycle 1, resp_valid in cycle 2.
- Byte/half store: READ in cycle 1, MERGE in cycle 2, WRITE in cycle 3, resp_valid in cycle 4.
- Error: resp_valid with resp_err in cycle 1.
- req_ready drops the cycle after accept and returns in the cycle after resp_valid. Back-to-back: the next accept can occur on the edge ending the RESP/ERR cycle+1 (IDLE cycle).
- A request held with req_valid while req_ready=0 is not lost; it is accepted when the unit returns to IDLE.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0, all latched request fields 0.
- Reset mid-operation takes effect immediately and asynchronously: strobes drop, the in-flight request is dropped, and no response is issued.

## Test plan
- Reset, then idle: all outputs match reset values; req_ready=1; no strobes for 10 cycles.
- Word store 0xDEADBEEF to 0x0C, then word load from 0x0C: mem_wr in cycle 1 with mem_addr=3; load resp_rdata=0xDEADBEEF in cycle 2; resp_err=0.
- Byte store 0xAA to 0x0D over word 0x11223344: READ, MERGE, WRITE sequence with mem_wdata=0x1122AA44, resp in cycle 4. Signed byte load from 0x0D returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Half load from 0x0E, word 0x8000_1234: signed returns 0xFFFF8000, unsigned returns 0x00008000. Half load from 0x0C returns 0x00001234.
- Half load at 0x01, word store at 0x06, size 11: each yields resp_err=1 and resp_rdata=0 in cycle 1, with no mem_rd/mem_wr.
- Address wrap: word store at 0x80 (ADDR_W=5) hits mem_addr=0. rst asserted during a byte store's MERGE: mem_wr never pulses, no resp_valid, memory word unchanged by this unit.
